// File: rtl/div4_sequencer_if.sv
// div4_if: start/operand/result bundle for div4_sequencer.
//   slave  modport: the sequencer (takes start + a..d, drives results).
//   master modport: the requester (drives start + a..d, takes results).
// Optional: DIV4_REMAINDER_EN adds the remainder result signal.
interface div4_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             res_valid;
    logic [1:0]       res_sel;
    logic [WIDTH-1:0] quotient;
    logic             error;
    logic [3:0]       err_mask;
    logic             done;
`ifdef DIV4_REMAINDER_EN
    logic [WIDTH-1:0] remainder;

    modport slave  (input  start, a, b, c, d,
                    output busy, res_valid, res_sel, quotient, error, err_mask, done, remainder);
    modport master (output start, a, b, c, d,
                    input  busy, res_valid, res_sel, quotient, error, err_mask, done, remainder);
`else
    modport slave  (input  start, a, b, c, d,
                    output busy, res_valid, res_sel, quotient, error, err_mask, done);
    modport master (output start, a, b, c, d,
                    input  busy, res_valid, res_sel, quotient, error, err_mask, done);
`endif
endinterface

// File: rtl/div4_sequencer.sv
// div4_sequencer: one shared restoring divider run over the four rotated
// operand pairs a/b, b/c, c/d, d/a after a single start command.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - div4_if.slave: start, a..d in; busy, res_valid, res_sel,
//          quotient, error, err_mask, done (and remainder) out
//
// Optional feature macro: DIV4_REMAINDER_EN -- also registers the true
// remainder (0 on divide-by-zero) alongside the quotient.
//
// Each pair costs LOAD + WIDTH DIVIDE cycles + EMIT, or LOAD + EMIT when the
// divisor is zero. Result registers are loaded on the transition into EMIT so
// they are already valid during the res_valid cycle, and they hold until the
// next EMIT.
module div4_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    div4_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] op_a, op_b, op_c, op_d;

    // Divider datapath: dvd shifts the dividend out MSB-first while the
    // quotient bits shift in, so it ends up holding the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sel_n, sel_d;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

    logic             res_valid_q, error_q, done_q;
    logic [1:0]       res_sel_q;
    logic [WIDTH-1:0] quotient_q;
    logic [3:0]       err_mask_q;
`ifdef DIV4_REMAINDER_EN
    logic [WIDTH-1:0] remainder_q;
`endif

    // Rotated pair selection: dividend = op[idx], divisor = op[idx+1 mod 4].
    always_comb begin
        sel_n = op_a;
        sel_d = op_b;
        case (idx)
            2'd0: begin sel_n = op_a; sel_d = op_b; end
            2'd1: begin sel_n = op_b; sel_d = op_c; end
            2'd2: begin sel_n = op_c; sel_d = op_d; end
            default: begin sel_n = op_d; sel_d = op_a; end
        endcase
    end

    // One restoring step. r_sh is the WIDTH+1-bit partial remainder after
    // shifting in the next dividend bit. Because the stored remainder is
    // always below the divisor, r_sh < 2*dvs, so the trial difference's top
    // bit is set exactly when the subtraction borrows (restore case).
    always_comb begin
        r_sh  = {prem, dvd[WIDTH-1]};
        diff  = r_sh - {1'b0, dvs};
        ge    = ~diff[WIDTH];
        r_nxt = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_nxt = {dvd[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            op_d        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
            res_sel_q   <= 2'd0;
            quotient_q  <= '0;
            error_q     <= 1'b0;
            err_mask_q  <= 4'd0;
            done_q      <= 1'b0;
`ifdef DIV4_REMAINDER_EN
            remainder_q <= '0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_a       <= bus.a;
                        op_b       <= bus.b;
                        op_c       <= bus.c;
                        op_d       <= bus.d;
                        err_mask_q <= 4'd0;
                        idx        <= 2'd0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (sel_d == '0) begin
                        // Divide-by-zero short-circuits straight to EMIT.
                        quotient_q      <= '1;
                        error_q         <= 1'b1;
                        res_sel_q       <= idx;
                        res_valid_q     <= 1'b1;
                        err_mask_q[idx] <= 1'b1;
`ifdef DIV4_REMAINDER_EN
                        remainder_q     <= '0;
`endif
                        state           <= S_EMIT;
                    end else begin
                        dvd   <= sel_n;
                        dvs   <= sel_d;
                        prem  <= '0;
                        cnt   <= '0;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    dvd  <= q_nxt;
                    prem <= r_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_IT) begin
                        quotient_q  <= q_nxt;
                        error_q     <= 1'b0;
                        res_sel_q   <= idx;
                        res_valid_q <= 1'b1;
`ifdef DIV4_REMAINDER_EN
                        remainder_q <= r_nxt;
`endif
                        state       <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (idx == 2'd3) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_sel   = res_sel_q;
    assign bus.quotient  = quotient_q;
    assign bus.error     = error_q;
    assign bus.err_mask  = err_mask_q;
    assign bus.done      = done_q;
`ifdef DIV4_REMAINDER_EN
    assign bus.remainder = remainder_q;
`endif

endmodule

// File: tb/tb_div4_sequencer.sv
// Self-checking bench for div4_sequencer: directed test-plan runs plus random
// operand sets, each compared cycle by cycle against an arithmetic model of
// result values and result timing.
module tb_div4_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div4_if #(.WIDTH(W)) bus ();

    div4_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":busy"},      32'(bus.busy),      0);
        chk({tag, ":res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, ":res_sel"},   32'(bus.res_sel),   0);
        chk({tag, ":quotient"},  32'(bus.quotient),  0);
        chk({tag, ":error"},     32'(bus.error),     0);
        chk({tag, ":err_mask"},  32'(bus.err_mask),  0);
        chk({tag, ":done"},      32'(bus.done),      0);
`ifdef DIV4_REMAINDER_EN
        chk({tag, ":remainder"}, 32'(bus.remainder), 0);
`endif
    endtask

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 4) == 0) return '0;
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    // One full run. The model derives every result and its cycle from plain
    // division and the per-pair cycle cost; cycle 0 is the start cycle.
    // disturb: change operands at cycle 3 and pulse start at cycle 5.
    // rst_at > 0: assert reset in that cycle and abandon the run.
    task automatic run(input logic [W-1:0] a, b, c, d, input bit disturb, input int rst_at);
        logic [W-1:0] ops [4];
        logic [W-1:0] eq  [4];
        logic [W-1:0] er  [4];
        bit           ee  [4];
        int           t_res [4];
        logic [3:0]   emask;
        int           t, t_done, k;
        bit           hit;
        logic [W-1:0] dv;

        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
        t = 0;
        emask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dv = ops[(i + 1) % 4];
            if (dv == 0) begin
                eq[i] = W'((1 << W) - 1);
                er[i] = '0;
                ee[i] = 1'b1;
                emask[i] = 1'b1;
                t += 2;
            end else begin
                eq[i] = ops[i] / dv;
                er[i] = ops[i] % dv;
                ee[i] = 1'b0;
                t += W + 2;
            end
            t_res[i] = t;
        end
        t_done = t + 1;

        @(negedge clk);
        bus.a = a; bus.b = b; bus.c = c; bus.d = d;
        bus.start = 1'b1;
        k = 0;
        for (int cyc = 1; cyc <= t_done + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (rst_at > 0 && cyc == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero("rst_mid");
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk("rst_hold:res_valid", 32'(bus.res_valid), 0);
                    chk("rst_hold:done",      32'(bus.done),      0);
                end
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("post_rst:res_valid", 32'(bus.res_valid), 0);
                    chk("post_rst:done",      32'(bus.done),      0);
                    chk("post_rst:busy",      32'(bus.busy),      0);
                end
                return;
            end
            if (disturb && cyc == 3) begin
                bus.a = rnd_op(); bus.b = rnd_op(); bus.c = rnd_op(); bus.d = rnd_op();
            end
            if (disturb && cyc == 5) bus.start = 1'b1;
            if (disturb && cyc == 6) bus.start = 1'b0;

            hit = (k < 4) && (cyc == t_res[k]);
            chk("res_valid", 32'(bus.res_valid), 32'(hit));
            chk("done",      32'(bus.done),      32'(cyc == t_done));
            chk("busy",      32'(bus.busy),      32'(cyc <= t_done));
            if (hit) begin
                chk("res_sel",  32'(bus.res_sel),  k);
                chk("quotient", 32'(bus.quotient), 32'(eq[k]));
                chk("error",    32'(bus.error),    32'(ee[k]));
`ifdef DIV4_REMAINDER_EN
                chk("remainder", 32'(bus.remainder), 32'(er[k]));
`endif
                k++;
            end else if (k > 0) begin
                chk("quotient_hold", 32'(bus.quotient), 32'(eq[k-1]));
            end
            if (cyc == t_done) chk("err_mask", 32'(bus.err_mask), 32'(emask));
        end
        chk("err_mask_held", 32'(bus.err_mask), 32'(emask));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        run(8'd15, 8'd2,   8'd12, 8'd12,  1'b0, 0);
        run(8'd0,  8'd8,   8'd12, 8'd12,  1'b0, 0);
        run(8'd87, 8'd202, 8'd2,  8'd1,   1'b0, 0);
        run(8'd1,  8'd1,   8'd1,  8'd255, 1'b0, 0);
        run(8'd15, 8'd2,   8'd12, 8'd12,  1'b1, 0);
        run(8'd200, 8'd3,  8'd0,  8'd9,   1'b0, 15);
        run(8'd15, 8'd2,   8'd12, 8'd12,  1'b0, 0);
        run(8'd0,  8'd0,   8'd0,  8'd0,   1'b0, 0);
        run(8'd255, 8'd1,  8'd255, 8'd255, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            run(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'(r % 3 == 0), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/div4_sequencer.md
# div4_sequencer

- Sequential controller that shares one iterative restoring divider across the four rotated operand pairs A/B, B/C, C/D, D/A.
- On one start command it latches A–D and computes all four quotients in order, emitting one result per pair with a divide-by-zero flag.
- It is the multi-cycle replacement for the combinational select-driven divider in the same datapath.

## Interface
- WIDTH, 8, operand/quotient width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- A, B, C, D  input  WIDTH each  unsigned operands, sampled on start acceptance
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- res_valid  output  1  one-cycle pulse per pair result
- res_sel  output  2  pair index of current result (0:A/B, 1:B/C, 2:C/D, 3:D/A)
- quotient  output  WIDTH  result quotient; valid when res_valid
- error  output  1  divisor was zero for this result; valid when res_valid
- err_mask  output  4  bit i set if pair i divisor was zero; cleared on acceptance, held after done
- done  output  1  one-cycle pulse after the fourth result

## Operation
- States: IDLE, LOAD, DIVIDE, EMIT, DONE.
- IDLE: if start, latch A–D, clear err_mask, set pair index to 0 → LOAD. If start is low, stay in IDLE.
- LOAD: select dividend/divisor for the current index.
  - Divisor == 0 → EMIT with quotient = all ones and error = 1.
  - Otherwise clear the partial remainder and iteration counter → DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide.
  - After exactly WIDTH iterations → EMIT.
- EMIT: res_valid = 1; res_sel = index; err_mask[index] |= error.
  - If index == 3 → DONE; else increment index → LOAD.
- DONE: done = 1 → IDLE.
- start while busy (LOAD/DIVIDE/EMIT/DONE) is ignored, not queued.
- Operand changes after acceptance are ignored.
- Arithmetic is unsigned. The quotient never exceeds WIDTH bits; x/1 = x with error = 0.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Per-pair latency:
  - Nonzero divisor: LOAD 1 + DIVIDE WIDTH + EMIT 1 = WIDTH+2 cycles.
  - Zero divisor: LOAD 1 + EMIT 1 = 2 cycles.
- No zero divisors, WIDTH=8: res_valid in cycles 10, 20, 30, 40; done in cycle 41; IDLE (busy = 0) in cycle 42.
- A new start can be accepted in cycle 42.
- quotient, error, res_sel are registered and held until the next EMIT; res_valid and done are one cycle wide.
- Reset values: busy 0, res_valid 0, res_sel 0, quotient 0, error 0, err_mask 0, done 0, state IDLE.
- Reset takes effect immediately and asynchronously, including mid-operation.
  - In-progress work is discarded; no res_valid or done follows.

## Configuration
- DIV4_REMAINDER_EN defined:
  - Adds output port remainder [WIDTH], registered with quotient in EMIT.
  - Value is the true remainder, or 0 when error = 1.
  - Reset value is 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- A=15, B=2, C=12, D=12, start pulse → results (sel, quotient, error):
  - (0,7,0) at cycle 10, (1,0,0) at cycle 20, (2,1,0) at cycle 30, (3,0,0) at cycle 40.
  - done at cycle 41; err_mask = 4'b0000.
- A=0, B=8, C=12, D=12 → (0,0,0)@10, (1,0,0)@20, (2,1,0)@30, (3,255,1)@32; done@33; err_mask = 4'b1000.
- A=87, B=202, C=2, D=1 → quotients 0, 101, 2, 0.
  - With DIV4_REMAINDER_EN: remainders 87, 0, 0, 1.
- A=1, B=1, C=1, D=255 → pair 3 gives quotient 255 with error = 0.
- Start pulse at cycle 5 and operand change at cycle 3 of a run → ignored; results match the originally latched operands.
- rst asserted at cycle 15 of a run → all outputs 0 immediately, no further res_valid/done. A fresh start after release completes normally.
